exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage ARM pipeline, sitting between the ID/EX register and `mem_stage`. It computes the ALU result and the branch target, owns the NZCV status register, and drives the EX/MEM pipeline register that feeds `mem_stage`. It honours the `mem_stage` freeze and can optionally host an iterative 32-cycle multiplier that stalls the front end.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `freeze_i` in 1: `freeze_o` of `mem_stage`. While high, EX/MEM, status and multiplier state all hold.
- `exe_cmd_i` in 4: ALU command.
- `s_i` in 1: update status register.
- `wb_en_i`, `mem_r_en_i`, `mem_w_en_i` in 1 each: control bits passed through to EX/MEM.
- `val1_i` in 32: Rn operand.
- `val2_i` in 32: shifted operand 2 or immediate, already generated.
- `val_rm_i` in 32: store data.
- `dest_i` in 4: destination register.
- `pc_i` in 32: PC+4 of the instruction.
- `imm24_i` in 24: branch offset.
- `stall_o` out 1: hold IF/ID/EX (multiplier busy).
- `status_o` out 4: {N,Z,C,V}, registered.
- `branch_addr_o` out 32: combinational, pc_i + (sign_ext(imm24_i) << 2).
- `wb_en_o`, `mem_r_en_o`, `mem_w_en_o` out 1 each: registered EX/MEM controls.
- `alu_res_o` out 32: registered.
- `val_rm_o` out 32: registered.
- `dest_o` out 4: registered.

## Operation
- exe_cmd encoding and results:
  - 0001 MOV: b.
  - 1001 MVN: ~b.
  - 0010 ADD: a+b.
  - 0011 ADC: a+b+C.
  - 0100 SUB: a-b.
  - 0101 SBC: a-b-!C.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - 1111 MUL (see Configuration).
  - Others: result 0, flags unchanged.
  - a = val1_i, b = val2_i.
- Arithmetic is on 33 bits.
  - Subtraction is computed as a + ~b + 1 (SBC: a + ~b + C).
  - C = bit 32, i.e. no-borrow for subtraction.
  - V (add): a[31]==b'[31] && r[31]!=a[31], where b' is the operand actually added.
- Flags: N = r[31], Z = (r==0). Logical ops and MOV/MVN leave C and V unchanged.
- Status register loads on clk when s_i && !freeze_i && !stall_o. For MUL, the load happens in the DONE cycle; only N and Z change.
- EX/MEM register:
  - If freeze_i: hold.
  - Else if stall_o: load a bubble (wb/mem enables 0, data fields 0).
  - Else: load the stage inputs and result.

## Timing
- Reset (async): all EX/MEM outputs 0, status_o 0000, multiplier IDLE, stall_o 0.
- Non-MUL ops: 1-cycle latency. Result is visible on `alu_res_o` the cycle after issue, unless frozen.
- Freeze: every registered output holds while freeze_i=1 and updates on the first edge with freeze_i=0.
- Simultaneous s_i and freeze_i: flags do not update until the instruction actually advances.
- branch_addr_o has no clock dependency. Offset 0xFFFFFF with pc_i 0x100 gives 0xFC.

## Configuration
- Macro `EXE_ITER_MUL_EN`.
- Defined — MUL state machine (shift-add, low 32 bits of product):
  - IDLE: when a MUL is present and freeze_i=0, stall_o=1. Load mcand=a, mplr=b, acc=0, cnt=0, then go to RUN.
  - RUN: stall_o=1. Each unfrozen cycle: if mplr[0], acc+=mcand; then mcand<<=1, mplr>>=1, cnt++. When cnt==31, go to DONE.
  - DONE: stall_o=0. EX/MEM captures acc with the instruction's controls; go to IDLE. If freeze_i, stay in DONE.
  - Issue to EX/MEM capture takes 34 cycles. During that time EX/MEM receives 33 bubbles.
- Undefined: cmd 1111 is reserved (result 0, flags unchanged, no stall). The multiplier logic is absent and stall_o is tied 0.

## Test plan
- Reset mid-MUL, asserted at RUN cnt=10 → next cycle stall_o=0, status 0000, all EX/MEM outputs 0.
- ADD, s=1, a=0x7FFFFFFF, b=1 → alu_res 0x80000000, NZCV=1001 one cycle later.
- SUB, s=1, a=5, b=5 → res 0, NZCV=0110. Then SBC with a=5, b=2, C=1 → res 3, C=1.
- AND, s=1, with freeze_i high for 3 cycles → outputs and status hold for those 3 cycles and update on the first unfrozen edge; C and V are preserved.
- With EXE_ITER_MUL_EN: MUL 0x12345678 × 0x10 (s=1) → stall_o high for 33 cycles, 33 bubbles, then res 0x23456780 with N=0, Z=0, and C/V untouched.
- Without EXE_ITER_MUL_EN: cmd 1111 → res 0, stall_o never asserts.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch target, NZCV status and the EX/MEM pipeline register.
// Define EXE_ITER_MUL_EN to add the iterative 32-cycle shift-add multiplier (cmd 1111).
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze_i,
  input  logic [3:0]  exe_cmd_i,
  input  logic        s_i,
  input  logic        wb_en_i,
  input  logic        mem_r_en_i,
  input  logic        mem_w_en_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [31:0] val_rm_i,
  input  logic [3:0]  dest_i,
  input  logic [31:0] pc_i,
  input  logic [23:0] imm24_i,
  output logic        stall_o,
  output logic [3:0]  status_o,
  output logic [31:0] branch_addr_o,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic        mem_w_en_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] val_rm_o,
  output logic [3:0]  dest_o
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]  status_q, status_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  dest_q, dest_d;

  logic        stall;
  logic        mul_done;
  logic [31:0] mul_acc;

  logic [31:0] op_b;
  logic        cin;
  logic        use_sum;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        upd_nz;
  logic        upd_cv;
  logic [31:0] res;
  logic        res_upd_nz;
  logic        res_upd_cv;
  logic        ovf;

  // Sign-extended word offset added to PC+4.
  assign branch_addr_o = pc_i + {{6{imm24_i[23]}}, imm24_i, 2'b00};

`ifdef EXE_ITER_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  mul_state_e  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (exe_cmd_i == 4'b1111 && !freeze_i) begin
          stall   = 1'b1;
          mcand_d = val1_i;
          mplr_d  = val2_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        stall = 1'b1;
        if (!freeze_i) begin
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (!freeze_i) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign mul_done = (state_q == MUL_DONE);
  assign mul_acc  = acc_q;
`else
  assign stall    = 1'b0;
  assign mul_done = 1'b0;
  assign mul_acc  = '0;
`endif

  assign stall_o = stall;

  // Subtraction reuses the adder as a + ~b + carry-in, so C is no-borrow.
  always_comb begin
    op_b    = val2_i;
    cin     = 1'b0;
    use_sum = 1'b0;
    upd_nz  = 1'b0;
    upd_cv  = 1'b0;
    alu_res = '0;
    case (exe_cmd_i)
      CMD_MOV: begin alu_res = val2_i;           upd_nz = 1'b1; end
      CMD_MVN: begin alu_res = ~val2_i;          upd_nz = 1'b1; end
      CMD_ADD: use_sum = 1'b1;
      CMD_ADC: begin cin = status_q[1];          use_sum = 1'b1; end
      CMD_SUB: begin op_b = ~val2_i; cin = 1'b1; use_sum = 1'b1; end
      CMD_SBC: begin op_b = ~val2_i; cin = status_q[1]; use_sum = 1'b1; end
      CMD_AND: begin alu_res = val1_i & val2_i;  upd_nz = 1'b1; end
      CMD_ORR: begin alu_res = val1_i | val2_i;  upd_nz = 1'b1; end
      CMD_EOR: begin alu_res = val1_i ^ val2_i;  upd_nz = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, val1_i} + {1'b0, op_b} + {32'd0, cin};
    if (use_sum) begin
      alu_res = sum[31:0];
      upd_nz  = 1'b1;
      upd_cv  = 1'b1;
    end
  end

  assign ovf        = (val1_i[31] == op_b[31]) && (sum[31] != val1_i[31]);
  assign res        = mul_done ? mul_acc : alu_res;
  assign res_upd_nz = mul_done | upd_nz;
  assign res_upd_cv = !mul_done & upd_cv;

  // Flags only move when the instruction really leaves EX.
  always_comb begin
    status_d = status_q;
    if (s_i && !freeze_i && !stall) begin
      if (res_upd_nz) status_d[3:2] = {res[31], (res == 32'd0)};
      if (res_upd_cv) status_d[1:0] = {sum[32], ovf};
    end
  end

  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    val_rm_d   = val_rm_q;
    dest_d     = dest_q;
    if (!freeze_i) begin
      if (stall) begin
        wb_en_d    = 1'b0;
        mem_r_en_d = 1'b0;
        mem_w_en_d = 1'b0;
        alu_res_d  = '0;
        val_rm_d   = '0;
        dest_d     = '0;
      end else begin
        wb_en_d    = wb_en_i;
        mem_r_en_d = mem_r_en_i;
        mem_w_en_d = mem_w_en_i;
        alu_res_d  = res;
        val_rm_d   = val_rm_i;
        dest_d     = dest_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
    end else begin
      status_q   <= status_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
    end
  end

  assign status_o   = status_q;
  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign mem_w_en_o = mem_w_en_q;
  assign alu_res_o  = alu_res_q;
  assign val_rm_o   = val_rm_q;
  assign dest_o     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed, table-driven bench for exe_stage; the multiplier sequences compile only
// when EXE_ITER_MUL_EN is defined, the reserved-cmd sequence only when it is not.
module tb_exe_stage;

  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011;
  localparam logic [3:0] SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111;
  localparam logic [3:0] EOR = 4'b1000, MUL = 4'b1111, NOP = 4'b0000;

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [31:0] exp_res;
    logic [3:0]  exp_nzcv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze_i = 1'b0;
  logic [3:0]  exe_cmd_i = '0;
  logic        s_i = 1'b0;
  logic        wb_en_i = 1'b0, mem_r_en_i = 1'b0, mem_w_en_i = 1'b0;
  logic [31:0] val1_i = '0, val2_i = '0, val_rm_i = '0, pc_i = '0;
  logic [3:0]  dest_i = '0;
  logic [23:0] imm24_i = '0;
  logic        stall_o, wb_en_o, mem_r_en_o, mem_w_en_o;
  logic [3:0]  status_o, dest_o;
  logic [31:0] branch_addr_o, alu_res_o, val_rm_o;

  int errors = 0;
  int checks = 0;
  vec_t vecs[13];

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze_i(freeze_i), .exe_cmd_i(exe_cmd_i), .s_i(s_i),
    .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i), .mem_w_en_i(mem_w_en_i),
    .val1_i(val1_i), .val2_i(val2_i), .val_rm_i(val_rm_i), .dest_i(dest_i),
    .pc_i(pc_i), .imm24_i(imm24_i), .stall_o(stall_o), .status_o(status_o),
    .branch_addr_o(branch_addr_o), .wb_en_o(wb_en_o), .mem_r_en_o(mem_r_en_o),
    .mem_w_en_o(mem_w_en_o), .alu_res_o(alu_res_o), .val_rm_o(val_rm_o), .dest_o(dest_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    exe_cmd_i  = v.cmd;
    s_i        = v.s;
    val1_i     = v.a;
    val2_i     = v.b;
    val_rm_i   = v.rm;
    dest_i     = v.dest;
    wb_en_i    = v.wb;
    mem_r_en_i = v.mr;
    mem_w_en_i = v.mw;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkExMem(input string tag, input logic [31:0] res, input logic [3:0] nzcv,
                            input logic [3:0] dest, input logic wb, input logic mr,
                            input logic mw, input logic [31:0] rm);
    checkOutput({tag, " alu_res"}, alu_res_o, res);
    checkOutput({tag, " status"}, {28'd0, status_o}, {28'd0, nzcv});
    checkOutput({tag, " dest"}, {28'd0, dest_o}, {28'd0, dest});
    checkOutput({tag, " ctrl"}, {29'd0, wb_en_o, mem_r_en_o, mem_w_en_o}, {29'd0, wb, mr, mw});
    checkOutput({tag, " val_rm"}, val_rm_o, rm);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int k;

    vecs[0]  = '{ADD, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'hA0A0A0A0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b1001};
    vecs[1]  = '{SUB, 1'b1, 32'h00000005, 32'h00000005, 32'h11111111, 4'd2, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0110};
    vecs[2]  = '{SBC, 1'b1, 32'h00000005, 32'h00000002, 32'h22222222, 4'd3, 1'b0, 1'b0, 1'b1, 32'h00000003, 4'b0010};
    vecs[3]  = '{ADC, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h33333333, 4'd4, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'b0110};
    vecs[4]  = '{MOV, 1'b1, 32'h12345678, 32'h80000000, 32'h44444444, 4'd5, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b1010};
    vecs[5]  = '{MVN, 1'b0, 32'h00000000, 32'h00000000, 32'h55555555, 4'd6, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b1010};
    vecs[6]  = '{ORR, 1'b1, 32'h00000000, 32'h00000000, 32'h66666666, 4'd7, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'b0110};
    vecs[7]  = '{EOR, 1'b1, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h77777777, 4'd8, 1'b1, 1'b0, 1'b0, 32'h0F0F0F0F, 4'b0010};
    vecs[8]  = '{SUB, 1'b1, 32'h00000000, 32'h00000001, 32'h88888888, 4'd9, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b1000};
    vecs[9]  = '{SBC, 1'b1, 32'h80000000, 32'h00000000, 32'h99999999, 4'd10, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0011};
    vecs[10] = '{NOP, 1'b1, 32'h00000003, 32'h00000004, 32'hAAAAAAAA, 4'd11, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0011};
    vecs[11] = '{ADD, 1'b0, 32'h00000010, 32'h00000020, 32'hBBBBBBBB, 4'd12, 1'b1, 1'b1, 1'b1, 32'h00000030, 4'b0011};
    vecs[12] = '{AND, 1'b1, 32'h000000FF, 32'h0000000F, 32'hCCCCCCCC, 4'd13, 1'b1, 1'b0, 1'b0, 32'h0000000F, 4'b0011};

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkExMem("reset", 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset stall", {31'd0, stall_o}, 32'd0);

    pc_i = 32'h00000100; imm24_i = 24'hFFFFFF;
    #1 checkOutput("branch back", branch_addr_o, 32'h000000FC);
    pc_i = 32'h00001000; imm24_i = 24'h000010;
    #1 checkOutput("branch fwd", branch_addr_o, 32'h00001040);

    @(negedge clk);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkExMem($sformatf("v%0d", i), vecs[i].exp_res, vecs[i].exp_nzcv, vecs[i].dest,
                 vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].rm);
    end

    $display("[TB] freeze hold");
    @(negedge clk);
    v = '{AND, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'hDDDDDDDD, 4'd14, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0};
    applyStimulus(v);
    freeze_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkExMem($sformatf("frz%0d", c), 32'h0000000F, 4'b0011, 4'd13, 1'b1, 1'b0, 1'b0, 32'hCCCCCCCC);
    end
    @(negedge clk);
    freeze_i = 1'b0;
    @(posedge clk);
    #1;
    checkExMem("unfrz", 32'h80000000, 4'b1011, 4'd14, 1'b0, 1'b1, 1'b0, 32'hDDDDDDDD);

`ifndef EXE_ITER_MUL_EN
    $display("[TB] reserved cmd 1111");
    @(negedge clk);
    v = '{MUL, 1'b1, 32'h00000005, 32'h00000006, 32'h0000EEEE, 4'd15, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0};
    applyStimulus(v);
    #1 checkOutput("rsv stall comb", {31'd0, stall_o}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rsv stall%0d", c), {31'd0, stall_o}, 32'd0);
      checkExMem($sformatf("rsv%0d", c), 32'h0, 4'b1011, 4'd15, 1'b1, 1'b0, 1'b0, 32'h0000EEEE);
    end
`else
    $display("[TB] iterative multiply");
    @(negedge clk);
    v = '{MUL, 1'b1, 32'h12345678, 32'h00000010, 32'h0000EEEE, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0};
    applyStimulus(v);
    #1 checkOutput("mul stall issue", {31'd0, stall_o}, 32'd1);
    k = 0;
    while (stall_o === 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      checkOutput($sformatf("bubble%0d", k), {alu_res_o[30:0], wb_en_o}, 32'd0);
      checkOutput($sformatf("bubble%0d dest", k), {28'd0, dest_o}, 32'd0);
    end
    checkOutput("mul stall cycles", k, 33);
    @(posedge clk);
    #1;
    checkExMem("mul done", 32'h23456780, 4'b0011, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0000EEEE);

    $display("[TB] reset during multiply");
    @(negedge clk);
    applyStimulus(v);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid-mul stall", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    exe_cmd_i = NOP;
    s_i = 1'b0;
    #1;
    checkOutput("rst mid-mul stall", {31'd0, stall_o}, 32'd0);
    checkExMem("rst mid-mul", 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst next stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
